// File: rtl/ram_1w1r_fifo_ctrl.sv
// Streaming FIFO controller around an external 1W1R block RAM with registered read data.
// A two-entry prefetch stage hides the RAM read latency so the output side sustains one word per cycle.
`timescale 1ns/1ps

module ram_1w1r_fifo_ctrl #(
    parameter  int DATA_WIDTH = 4096,
    parameter  int DEPTH      = 64,
    localparam int AW         = $clog2(DEPTH - 1) + 1,
    localparam int CW         = $clog2(DEPTH + 3)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  ram_we,
    output logic [AW-1:0]         ram_write_addr,
    output logic [AW-1:0]         ram_read_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]         r_wrPtr;
    logic [PW-1:0]         r_rdPtr;
    logic [CW-1:0]         r_ramCnt;
    logic                  r_rdPend;
    logic [1:0]            r_outCnt;
    logic [DATA_WIDTH-1:0] r_q0;
    logic [DATA_WIDTH-1:0] r_q1;

    logic                  w_sReady;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_occAfterPop;
    logic [1:0]            w_outAfterPop;

    // ram_cnt excludes this cycle's push, so a read never targets the word being written.
    assign w_sReady      = rst_n & ~flush & (r_ramCnt < CW'(DEPTH));
    assign w_push        = s_valid & w_sReady;
    assign w_pop         = (r_outCnt != 2'd0) & m_ready & ~flush;
    assign w_outAfterPop = r_outCnt - {1'b0, w_pop};
    assign w_occAfterPop = {1'b0, w_outAfterPop} + {2'b00, r_rdPend};
    assign w_issue       = (r_ramCnt != '0) & (w_occAfterPop < 3'd2) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_ramCnt <= '0;
            r_rdPend <= 1'b0;
            r_outCnt <= 2'd0;
        end else if (flush) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_ramCnt <= '0;
            r_rdPend <= 1'b0;
            r_outCnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_issue) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_ramCnt <= r_ramCnt + CW'(w_push) - CW'(w_issue);
            r_rdPend <= w_issue;
            r_outCnt <= w_outAfterPop + {1'b0, r_rdPend};
        end
    end

    // Returning read data lands in the first slot left free once this cycle's pop has shifted q1 down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q0 <= '0;
            r_q1 <= '0;
        end else if (!flush) begin
            if (w_pop) begin
                r_q0 <= r_q1;
            end
            if (r_rdPend) begin
                if (w_outAfterPop == 2'd0) begin
                    r_q0 <= ram_dout;
                end else begin
                    r_q1 <= ram_dout;
                end
            end
        end
    end

    assign s_ready        = w_sReady;
    assign full           = rst_n & ~w_sReady;
    assign ram_we         = w_push;
    assign ram_din        = s_data;
    assign ram_write_addr = AW'(r_wrPtr);
    assign ram_read_addr  = AW'(r_rdPtr);
    assign m_valid        = (r_outCnt != 2'd0);
    assign m_data         = r_q0;
    assign count          = r_ramCnt + CW'(r_rdPend) + CW'(r_outCnt);
    assign empty          = (count == '0);

endmodule
